// File: rtl/ahb_lite_cmd_master.sv
// Single-outstanding AHB-Lite initiator: one valid/ready command becomes one
// NONSEQ transfer, with a valid/ready response carrying read data and status.
module ahb_lite_cmd_master #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter logic [3:0]  HPROT_VALUE = 4'b0011
) (
  input  logic                  HCLK,
  input  logic                  RESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic [31:0]           cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  HSEL,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [3:0]            HPROT,
  output logic [31:0]           HWDATA,
  input  logic                  HREADY,
  input  logic [31:0]           HRDATA,
  input  logic                  HRESP
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_ERR  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  state_t                  state_q, state_d;
  logic                    hsel_q, hsel_d;
  logic [1:0]              htrans_q, htrans_d;
  logic [ADDR_WIDTH-1:0]   haddr_q, haddr_d;
  logic                    hwrite_q, hwrite_d;
  logic [2:0]              hsize_q, hsize_d;
  logic [31:0]             hwdata_q, hwdata_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [31:0]             rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    accept;
  logic                    cmd_bad;

  // Place a right-aligned item on every byte lane it may occupy.
  function automatic logic [31:0] replicate(input logic [31:0] d, input logic [2:0] size);
    case (size)
      3'd0:    return {4{d[7:0]}};
      3'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Pull the addressed lane out of HRDATA, right-aligned and zero-extended.
  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] a,
                                          input logic [2:0] size);
    logic [31:0] s;
    case (size)
      3'd0: begin
        s = d >> {a, 3'b000};
        return {24'h0, s[7:0]};
      end
      3'd1: begin
        s = d >> {a[1], 4'b0000};
        return {16'h0, s[15:0]};
      end
      default: return d;
    endcase
  endfunction

  assign cmd_ready = (state_q == S_IDLE) && !RESET;
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_bad   = (cmd_size > 3'd2)
                  || ((cmd_size == 3'd1) && cmd_addr[0])
                  || ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00));

  always_ff @(posedge HCLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      hsel_q      <= 1'b0;
      htrans_q    <= TRANS_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'd0;
      hwdata_q    <= 32'h0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hsel_q      <= hsel_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hwdata_q    <= hwdata_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = cmd_bad ? S_RESP : S_ADDR;
      S_ADDR: if (HREADY) state_d = S_DATA;
      S_DATA: begin
        if (HREADY)    state_d = S_RESP;
        else if (HRESP) state_d = S_ERR;
      end
      S_ERR:  if (HREADY) state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hsel_d      = hsel_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hwdata_d    = hwdata_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept && cmd_bad) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end else if (accept) begin
          hsel_d   = 1'b1;
          htrans_d = TRANS_NONSEQ;
          haddr_d  = cmd_addr;
          hwrite_d = cmd_write;
          hsize_d  = cmd_size;
          wdata_d  = replicate(cmd_wdata, cmd_size);
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          hsel_d   = 1'b0;
          htrans_d = TRANS_IDLE;
          hwdata_d = hwrite_q ? wdata_q : 32'h0;
        end
      end
      S_DATA: begin
        if (HREADY) begin
          hwdata_d    = 32'h0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = HRESP;
          rsp_rdata_d = (HRESP || hwrite_q) ? 32'h0 : extract(HRDATA, haddr_q[1:0], hsize_q);
        end else if (HRESP) begin
          hwdata_d = 32'h0;
        end
      end
      S_ERR: begin
        if (HREADY) begin
          hwdata_d    = 32'h0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end
      end
      S_RESP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  assign HSEL      = hsel_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HPROT     = HPROT_VALUE;
  assign HWDATA    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Bench for ahb_lite_cmd_master: directed vector table, randomized commands
// against a behavioural model, and hand-written reset sequences.
module tb_ahb_lite_cmd_master;
  localparam int AW = 16;

  logic          HCLK = 1'b0;
  logic          RESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_write;
  logic [2:0]    cmd_size;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          HSEL;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [3:0]    HPROT;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic [31:0]   HRDATA;
  logic          HRESP;

  ahb_lite_cmd_master #(.ADDR_WIDTH(AW), .HPROT_VALUE(4'b0011)) dut (
    .HCLK(HCLK), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [2:0]    size;
    logic [31:0]   wdata;
    int            nwait;
    int            emode;   // 0 OKAY, 1 two-cycle ERROR, 2 single-cycle ERROR
    logic [31:0]   hrdata;
    int            rdly;
    bit            exp_rej;
    logic [31:0]   exp_hwdata;
    logic [31:0]   exp_rdata;
    logic          exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Behavioural reference: alignment rule, lane replication and lane selection.
  function automatic bit model_reject(input logic [AW-1:0] a, input logic [2:0] s);
    int ai = int'(a);
    return (s > 3'd2) || (s == 3'd1 && (ai % 2) != 0) || (s == 3'd2 && (ai % 4) != 0);
  endfunction

  function automatic logic [31:0] model_lanes(input logic [31:0] d, input logic [2:0] s);
    if (s == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (s == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] d, input logic [AW-1:0] a,
                                             input logic [2:0] s);
    int ai = int'(a);
    if (s == 3'd0) return (d >> (8 * (ai % 4))) & 32'hFF;
    if (s == 3'd1) return (d >> (16 * ((ai / 2) % 2))) & 32'hFFFF;
    return d;
  endfunction

  function automatic vec_t mk(input logic [AW-1:0] addr, input logic wr, input logic [2:0] size,
                              input logic [31:0] wdata, input int nwait, input int emode,
                              input logic [31:0] hrdata, input int rdly, input bit rej,
                              input logic [31:0] hwd, input logic [31:0] rd, input logic err);
    vec_t v;
    v.addr = addr; v.wr = wr; v.size = size; v.wdata = wdata; v.nwait = nwait;
    v.emode = emode; v.hrdata = hrdata; v.rdly = rdly; v.exp_rej = rej;
    v.exp_hwdata = hwd; v.exp_rdata = rd; v.exp_err = err;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.addr  = AW'($urandom);
    v.size  = 3'($urandom_range(0, 3));
    if ($urandom_range(0, 3) != 0) begin
      v.size = 3'($urandom_range(0, 2));
      if (v.size == 3'd1) v.addr[0] = 1'b0;
      if (v.size == 3'd2) v.addr[1:0] = 2'b00;
    end
    v.wr     = 1'($urandom_range(0, 1));
    v.wdata  = $urandom;
    v.nwait  = $urandom_range(0, 3);
    v.emode  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
    v.hrdata = $urandom;
    v.rdly   = $urandom_range(0, 2);
    v.exp_rej    = model_reject(v.addr, v.size);
    v.exp_hwdata = v.wr ? model_lanes(v.wdata, v.size) : 32'h0;
    v.exp_err    = v.exp_rej || (v.emode != 0);
    v.exp_rdata  = (v.exp_err || v.wr) ? 32'h0 : model_read(v.hrdata, v.addr, v.size);
    return v;
  endfunction

  // Drives one command through, plays the target side, and checks every cycle.
  task automatic run_txn(input vec_t v);
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_write = v.wr; cmd_size = v.size;
    cmd_wdata = v.wdata; HREADY = 1'b1; HRESP = 1'b0; rsp_ready = 1'b0;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0; cmd_addr = AW'($urandom); cmd_wdata = $urandom;
    check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    if (!v.exp_rej) begin
      check("htrans_nonseq", 32'(HTRANS), 32'd2);
      check("hsel_addr", 32'(HSEL), 32'd1);
      check("haddr", 32'(HADDR), 32'(v.addr));
      check("hwrite", 32'(HWRITE), 32'(v.wr));
      check("hsize", 32'(HSIZE), 32'(v.size));
      check("hprot", 32'(HPROT), 32'h3);
      check("rsp_valid_addr", 32'(rsp_valid), 32'd0);
      tick();
      check("htrans_data", 32'(HTRANS), 32'd0);
      check("hsel_data", 32'(HSEL), 32'd0);
      check("hwdata", HWDATA, v.exp_hwdata);
      check("rsp_valid_data", 32'(rsp_valid), 32'd0);
      for (int i = 0; i < v.nwait; i++) begin
        HREADY = 1'b0; HRESP = 1'b0; HRDATA = $urandom;
        tick();
        check("hwdata_wait", HWDATA, v.exp_hwdata);
        check("rsp_valid_wait", 32'(rsp_valid), 32'd0);
        check("htrans_wait", 32'(HTRANS), 32'd0);
      end
      if (v.emode == 1) begin
        HREADY = 1'b0; HRESP = 1'b1; HRDATA = $urandom;
        tick();
        check("rsp_valid_err1", 32'(rsp_valid), 32'd0);
        check("hwdata_err1", HWDATA, 32'h0);
        HREADY = 1'b1; HRESP = 1'b1;
        tick();
      end else if (v.emode == 2) begin
        HREADY = 1'b1; HRESP = 1'b1; HRDATA = $urandom;
        tick();
      end else begin
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = v.hrdata;
        tick();
      end
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
    end
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_rdata", rsp_rdata, v.exp_rdata);
    check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    check("hwdata_resp", HWDATA, 32'h0);
    check("htrans_resp", 32'(HTRANS), 32'd0);
    for (int i = 0; i < v.rdly; i++) begin
      tick();
      check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
      check("rsp_rdata_hold", rsp_rdata, v.exp_rdata);
      check("rsp_err_hold", 32'(rsp_err), 32'(v.exp_err));
      check("cmd_ready_hold", 32'(cmd_ready), 32'd0);
      check("htrans_hold", 32'(HTRANS), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_done", 32'(rsp_valid), 32'd0);
    check("cmd_ready_done", 32'(cmd_ready), 32'd1);
  endtask

  vec_t vecs[11];

  initial begin
    RESET = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_size = 3'd0;
    cmd_wdata = 32'h0; rsp_ready = 1'b0; HREADY = 1'b1; HRDATA = 32'h0; HRESP = 1'b0;

    vecs[0]  = mk(16'h0004, 1'b1, 3'd2, 32'hDEADBEEF, 0, 0, 32'h0,        0, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0);
    vecs[1]  = mk(16'h0013, 1'b0, 3'd0, 32'h0,        0, 0, 32'hA1B2C3D4, 0, 1'b0, 32'h0,        32'h000000A1, 1'b0);
    vecs[2]  = mk(16'h0102, 1'b1, 3'd1, 32'h00005A5A, 3, 0, 32'h0,        0, 1'b0, 32'h5A5A5A5A, 32'h0,        1'b0);
    vecs[3]  = mk(16'h0020, 1'b0, 3'd2, 32'h0,        0, 1, 32'h0,        0, 1'b0, 32'h0,        32'h0,        1'b1);
    vecs[4]  = mk(16'h0020, 1'b0, 3'd3, 32'h0,        0, 0, 32'h0,        0, 1'b1, 32'h0,        32'h0,        1'b1);
    vecs[5]  = mk(16'h0006, 1'b1, 3'd2, 32'h12345678, 0, 0, 32'h0,        1, 1'b1, 32'h0,        32'h0,        1'b1);
    vecs[6]  = mk(16'h0008, 1'b0, 3'd2, 32'h0,        1, 0, 32'h12345678, 5, 1'b0, 32'h0,        32'h12345678, 1'b0);
    vecs[7]  = mk(16'h0002, 1'b0, 3'd1, 32'h0,        0, 0, 32'hA1B2C3D4, 0, 1'b0, 32'h0,        32'h0000A1B2, 1'b0);
    vecs[8]  = mk(16'h0040, 1'b1, 3'd2, 32'hCAFEF00D, 2, 2, 32'h0,        0, 1'b0, 32'hCAFEF00D, 32'h0,        1'b1);
    vecs[9]  = mk(16'h0001, 1'b1, 3'd0, 32'hFFFFFF3C, 0, 0, 32'h0,        0, 1'b0, 32'h3C3C3C3C, 32'h0,        1'b0);
    vecs[10] = mk(16'h0001, 1'b0, 3'd1, 32'h0,        0, 0, 32'h0,        0, 1'b1, 32'h0,        32'h0,        1'b1);

    // Reset state, observed while RESET is still high.
    tick();
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_hsel", 32'(HSEL), 32'd0);
    check("rst_htrans", 32'(HTRANS), 32'd0);
    check("rst_haddr", 32'(HADDR), 32'd0);
    check("rst_hwrite", 32'(HWRITE), 32'd0);
    check("rst_hsize", 32'(HSIZE), 32'd0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    RESET = 1'b0;
    #1;
    check("rst_cmd_ready_after", 32'(cmd_ready), 32'd1);
    tick();

    for (int i = 0; i < 11; i++) run_txn(vecs[i]);

    for (int i = 0; i < 40; i++) run_txn(rand_vec());

    // Reset while the data phase is stalled abandons the transfer.
    cmd_valid = 1'b1; cmd_addr = 16'h0010; cmd_write = 1'b0; cmd_size = 3'd2; HREADY = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("mid_in_data", 32'(HTRANS), 32'd0);
    HREADY = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    check("mid_rst_htrans", 32'(HTRANS), 32'd0);
    check("mid_rst_hsel", 32'(HSEL), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    RESET = 1'b0; HREADY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      check("post_rst_htrans", 32'(HTRANS), 32'd0);
      check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    end

    run_txn(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
